sar_sequencer: RTL and testbench

Parametrised successor to the fixed 8-bit SAR controller: it sequences one successive-approximation conversion per request.
- Sample phase: DAC held in reset.
- Bit trials: MSB to LSB, one-hot enables to the per-bit FSMs.

Unlike the fixed controller, it registers every comparator decision, including the LSB, into a result word. It also adds a start/done handshake, continuous mode, and programmable sample and settle lengths. It sits between the comparator (VCOMP) and the per-bit DAC FSMs in the ADC top level.

---
 rtl/sar_seq_pkg.sv | 25 ++
 rtl/sar_sequencer_if.sv | 24 ++
 rtl/sar_slot_timer.sv | 25 ++
 rtl/sar_sequencer.sv | 143 ++++++++++++++
 tb/tb_sar_sequencer.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/sar_seq_pkg.sv
// Shared types and elaboration helpers for the successive-approximation sequencer.
package sar_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAMPLE  = 2'd1,
        CONVERT = 2'd2
    } sar_state_e;

    // Number of bits needed to hold values 0..max_val (never less than one).
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) begin
            w = w + 1;
        end
        return w;
    endfunction

    function automatic bit params_legal(input int nbits, input int sample_cycles, input int settle_cycles);
        return (nbits >= 2) && (nbits <= 16) && (sample_cycles >= 1) &&
               (settle_cycles >= 0) && (settle_cycles <= 15);
    endfunction

endpackage

// File: rtl/sar_sequencer_if.sv
// Comparator / request side and DAC-FSM side signals of the sequencer.
interface sar_sequencer_if #(
    parameter int NBITS = 8
);
    logic             start;
    logic             cont;
    logic             vcomp;
    logic [NBITS-2:0] biten;
    logic             sar_reset;
    logic             busy;
    logic             done;
    logic [NBITS-1:0] data;
    logic             data_valid;

    modport master (
        output start, cont, vcomp,
        input  biten, sar_reset, busy, done, data, data_valid
    );

    modport slave (
        input  start, cont, vcomp,
        output biten, sar_reset, busy, done, data, data_valid
    );
endinterface

// File: rtl/sar_slot_timer.sv
// Loadable down-counter; o_tc flags the last cycle of a sample phase or bit slot.
module sar_slot_timer #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_tc
);
    logic [WIDTH-1:0] r_count;

    // Count down to zero and park there until the next load.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_tc = (r_count == '0);
endmodule

// File: rtl/sar_sequencer.sv
// SAR conversion sequencer: sample phase, MSB-first bit trials, result capture and handshake.
module sar_sequencer
    import sar_seq_pkg::*;
#(
    parameter int NBITS         = 8,
    parameter int SAMPLE_CYCLES = 1,
    parameter int SETTLE_CYCLES = 0
) (
    input  logic            i_clk,
    input  logic            i_reset,
    sar_sequencer_if.slave  bus
);
    localparam int TMAX = ((SAMPLE_CYCLES - 1) > SETTLE_CYCLES) ? (SAMPLE_CYCLES - 1) : SETTLE_CYCLES;
    localparam int TW   = cnt_width(TMAX);
    localparam int IW   = cnt_width(NBITS - 1);

    localparam logic [TW-1:0]    SAMPLE_LOAD = TW'(SAMPLE_CYCLES - 1);
    localparam logic [TW-1:0]    SETTLE_LOAD = TW'(SETTLE_CYCLES);
    localparam logic [IW-1:0]    MSB_IDX     = IW'(NBITS - 1);
    localparam logic [NBITS-2:0] BITEN_MSB   = (NBITS - 1)'(1) << (NBITS - 2);

    if (!params_legal(NBITS, SAMPLE_CYCLES, SETTLE_CYCLES)) begin : g_bad_params
        $error("sar_sequencer: illegal NBITS/SAMPLE_CYCLES/SETTLE_CYCLES");
    end

    sar_state_e       r_state;
    logic [IW-1:0]    r_bit_idx;
    logic [NBITS-1:0] r_work;
    logic [NBITS-1:0] r_data;
    logic [NBITS-2:0] r_biten;
    logic             r_done;
    logic             r_valid;
    logic             r_sar_reset;
    logic             r_busy;

    logic             w_tc;
    logic             w_load;
    logic [TW-1:0]    w_load_val;

    sar_slot_timer #(.WIDTH(TW)) u_timer (
        .i_clk      (i_clk),
        .i_rst      (i_reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_tc       (w_tc)
    );

    // Reload the timer whenever a phase or slot ends; slot 0 preloads the next sample phase.
    always_comb begin
        w_load     = 1'b0;
        w_load_val = SETTLE_LOAD;
        case (r_state)
            IDLE: begin
                w_load     = bus.start;
                w_load_val = SAMPLE_LOAD;
            end
            SAMPLE: begin
                w_load     = w_tc;
                w_load_val = SETTLE_LOAD;
            end
            CONVERT: begin
                w_load = w_tc;
                if (r_bit_idx == '0) begin
                    w_load_val = SAMPLE_LOAD;
                end else begin
                    w_load_val = SETTLE_LOAD;
                end
            end
            default: begin
                w_load     = 1'b0;
                w_load_val = SETTLE_LOAD;
            end
        endcase
    end

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_bit_idx   <= '0;
            r_work      <= '0;
            r_data      <= '0;
            r_biten     <= '0;
            r_done      <= 1'b0;
            r_valid     <= 1'b0;
            r_sar_reset <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state     <= SAMPLE;
                        r_busy      <= 1'b1;
                        r_sar_reset <= 1'b1;
                    end
                end
                SAMPLE: begin
                    if (w_tc) begin
                        r_state     <= CONVERT;
                        r_bit_idx   <= MSB_IDX;
                        r_biten     <= BITEN_MSB;
                        r_sar_reset <= 1'b0;
                    end
                end
                CONVERT: begin
                    if (w_tc) begin
                        r_work[r_bit_idx] <= bus.vcomp;
                        r_biten           <= r_biten >> 1'b1;
                        if (r_bit_idx == '0) begin
                            // The LSB decision bypasses r_work so DATA is complete this edge.
                            r_data      <= {r_work[NBITS-1:1], bus.vcomp};
                            r_done      <= 1'b1;
                            r_valid     <= 1'b1;
                            r_sar_reset <= 1'b1;
                            if (bus.cont) begin
                                r_state <= SAMPLE;
                            end else begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx - IW'(1);
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_biten     <= '0;
                    r_sar_reset <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.biten      = r_biten;
    assign bus.sar_reset  = r_sar_reset;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.data       = r_data;
    assign bus.data_valid = r_valid;
endmodule

// File: tb/tb_sar_sequencer.sv
// Bench for sar_sequencer: two configurations checked every cycle against a timeline model.
module tb_sar_sequencer;
    localparam int N0 = 8, S0 = 1, E0 = 0;
    localparam int N1 = 4, S1 = 3, E1 = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, cont = 1'b0, vcomp = 1'b0;

    always #5 clk = ~clk;

    sar_sequencer_if #(.NBITS(N0)) bus0();
    sar_sequencer_if #(.NBITS(N1)) bus1();

    assign bus0.start = start;
    assign bus0.cont  = cont;
    assign bus0.vcomp = vcomp;
    assign bus1.start = start;
    assign bus1.cont  = cont;
    assign bus1.vcomp = vcomp;

    sar_sequencer #(.NBITS(N0), .SAMPLE_CYCLES(S0), .SETTLE_CYCLES(E0)) dut0 (
        .i_clk(clk), .i_reset(rst), .bus(bus0));
    sar_sequencer #(.NBITS(N1), .SAMPLE_CYCLES(S1), .SETTLE_CYCLES(E1)) dut1 (
        .i_clk(clk), .i_reset(rst), .bus(bus1));

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_t is the cycle offset since START was accepted (0 = idle).
    int          m_t[2];
    logic [15:0] m_work[2];
    logic [15:0] m_data[2];
    bit          m_done[2];
    bit          m_valid[2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_t[d] = 0; m_work[d] = 16'h0; m_data[d] = 16'h0; m_done[d] = 1'b0; m_valid[d] = 1'b0;
        end
    end

    task automatic model_step(input int d, input int n, input int s, input int e);
        int tt, u, k;
        tt = e + 1;
        if (rst) begin
            m_t[d] = 0; m_work[d] = 16'h0; m_data[d] = 16'h0; m_done[d] = 1'b0; m_valid[d] = 1'b0;
        end else begin
            m_done[d] = 1'b0;
            if (m_t[d] == 0) begin
                if (start) m_t[d] = 1;
            end else begin
                if (m_t[d] > s) begin
                    u = m_t[d] - s - 1;
                    k = n - 1 - u / tt;
                    if (u % tt == tt - 1) m_work[d][k] = vcomp;
                end
                if (m_t[d] == s + n * tt) begin
                    m_data[d]  = m_work[d];
                    m_done[d]  = 1'b1;
                    m_valid[d] = 1'b1;
                    m_t[d]     = cont ? 1 : 0;
                end else begin
                    m_t[d] = m_t[d] + 1;
                end
            end
        end
    endtask

    function automatic logic [15:0] exp_biten(input int d, input int n, input int s, input int e);
        int k;
        logic [15:0] one;
        one = 16'h1;
        if (m_t[d] > s) begin
            k = n - 1 - (m_t[d] - s - 1) / (e + 1);
            if (k >= 1) return one << (k - 1);
        end
        return 16'h0;
    endfunction

    always @(posedge clk) begin
        model_step(0, N0, S0, E0);
        model_step(1, N1, S1, E1);
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("d0_biten",      32'(bus0.biten),      32'(exp_biten(0, N0, S0, E0)));
            check("d0_sar_reset",  32'(bus0.sar_reset),  32'(m_t[0] <= S0));
            check("d0_busy",       32'(bus0.busy),       32'(m_t[0] != 0));
            check("d0_done",       32'(bus0.done),       32'(m_done[0]));
            check("d0_data",       32'(bus0.data),       32'(m_data[0]));
            check("d0_data_valid", 32'(bus0.data_valid), 32'(m_valid[0]));
            check("d1_biten",      32'(bus1.biten),      32'(exp_biten(1, N1, S1, E1)));
            check("d1_sar_reset",  32'(bus1.sar_reset),  32'(m_t[1] <= S1));
            check("d1_busy",       32'(bus1.busy),       32'(m_t[1] != 0));
            check("d1_done",       32'(bus1.done),       32'(m_done[1]));
            check("d1_data",       32'(bus1.data),       32'(m_data[1]));
            check("d1_data_valid", 32'(bus1.data_valid), 32'(m_valid[1]));
        end
    end

    initial begin
        logic [7:0] pat;
        int cnt[3];

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_busy",  32'(bus0.busy),      32'h0);
        check("reset_sarr",  32'(bus0.sar_reset), 32'h1);
        check("reset_valid", 32'(bus0.data_valid), 32'h0);
        cmp_en = 1'b1;
        rst = 1'b0;

        // Default config, single conversion of 8'hB2.
        pat = 8'hB2;
        for (int c = 0; c <= 17; c++) begin
            @(negedge clk);
            if (c == 2) check("t1_biten_first", 32'(bus0.biten), 32'h40);
            if (c == 8) check("t1_biten_last",  32'(bus0.biten), 32'h01);
            if (c == 9) check("t1_biten_slot0", 32'(bus0.biten), 32'h00);
            if (c >= 1 && c <= 11) check("t1_done_timing", 32'(bus0.done), 32'(c == 10));
            if (c == 10) begin
                check("t1_data",       32'(bus0.data),       32'hB2);
                check("t1_model_data", 32'(m_data[0]),       32'hB2);
                check("t1_valid",      32'(bus0.data_valid), 32'h1);
            end
            start = (c == 0);
            vcomp = (c >= 2 && c <= 9) ? pat[9-c] : 1'b0;
        end

        // NBITS=4 / SAMPLE=3 / SETTLE=2, pattern 0,1,1,0.
        for (int j = 0; j < 3; j++) cnt[j] = 0;
        for (int c = 0; c <= 18; c++) begin
            @(negedge clk);
            for (int j = 0; j < 3; j++) cnt[j] += int'(bus1.biten[j]);
            if (c == 4) check("t3_biten_first", 32'(bus1.biten), 32'h4);
            if (c >= 1 && c <= 17) check("t3_done_timing", 32'(bus1.done), 32'(c == 16));
            if (c == 16) begin
                check("t3_data",       32'(bus1.data), 32'h6);
                check("t3_model_data", 32'(m_data[1]), 32'h6);
            end
            start = (c == 0);
            vcomp = (c == 9) || (c == 12);
        end
        for (int j = 0; j < 3; j++) check("t3_biten_width", 32'(cnt[j]), 32'd3);

        // Continuous mode, extra START while busy, CONT dropped mid-conversion.
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= 38) check("t2_done_period", 32'(bus0.done), 32'(c == 10 || c == 19 || c == 28));
            if (c == 10) check("t2_data_ff", 32'(bus0.data), 32'hFF);
            if (c == 19) check("t2_data_00", 32'(bus0.data), 32'h00);
            if (c >= 9 && c <= 11) check("t2_sar_reset_gap", 32'(bus0.sar_reset), 32'(c == 10));
            if (c == 25) check("t2_busy_mid", 32'(bus0.busy), 32'h1);
            if (c == 29) check("t2_idle_after", 32'(bus0.busy), 32'h0);
            start = (c == 0) || (c == 22);
            cont  = (c < 20);
            vcomp = (c < 10);
        end

        // Reset during slot 4, then a normal conversion of 8'h5A.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int c = 0; c <= 14; c++) begin
            @(negedge clk);
            if (c == 6) begin
                check("t4_busy",  32'(bus0.busy),       32'h0);
                check("t4_sarr",  32'(bus0.sar_reset),  32'h1);
                check("t4_biten", 32'(bus0.biten),      32'h0);
                check("t4_data",  32'(bus0.data),       32'h0);
                check("t4_valid", 32'(bus0.data_valid), 32'h0);
            end
            if (c >= 6) check("t4_no_done", 32'(bus0.done), 32'h0);
            start = (c == 0);
            rst   = (c == 5);
            vcomp = 1'b1;
        end
        pat = 8'h5A;
        for (int c = 0; c <= 17; c++) begin
            @(negedge clk);
            if (c == 10) begin
                check("t4_after_done", 32'(bus0.done), 32'h1);
                check("t4_after_data", 32'(bus0.data), 32'h5A);
            end
            start = (c == 0);
            vcomp = (c >= 2 && c <= 9) ? pat[9-c] : 1'b0;
        end

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = ($urandom % 5) == 0;
            if (($urandom % 40) == 0) cont = ~cont;
            vcomp = $urandom % 2;
            rst   = ($urandom % 400) == 0;
        end
        rst = 1'b0; start = 1'b0; cont = 1'b0;
        repeat (40) @(negedge clk);
        check("final_idle", 32'(bus0.busy | bus1.busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
